// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection, IF/ID pipeline register,
// sticky misaligned-redirect flag and an accepted-instruction counter.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Stall,
    input  logic        Flush,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IFID_pc,
    output logic [31:0] IFID_instr,
    output logic        IFID_valid,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        misalign_q, misalign_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic        run;
    logic        redirect;
    logic        accept;
    logic [31:0] target;

    assign run      = (state_q == RUN);
    assign imem_req = run;
    assign redirect = run & (PCSrc != 2'b00);
    assign accept   = run & imem_req & imem_ready & ~Stall & ~Flush & (PCSrc == 2'b00);

    always_comb begin
        target = TRAP_VEC;
        case (PCSrc)
            2'b01:   target = branch_target;
            2'b10:   target = jump_target;
            default: target = TRAP_VEC;
        endcase
    end

    always_comb begin
        state_d       = RUN;
        pc_d          = pc_q;
        misalign_d    = misalign_q;
        fetch_count_d = fetch_count_q;
        ifid_pc_d     = ifid_pc_q;
        ifid_instr_d  = ifid_instr_q;
        ifid_valid_d  = ifid_valid_q;

        // A redirect drops any data returned this cycle; the target is word-aligned.
        if (redirect) begin
            pc_d = {target[31:2], 2'b00};
            if (target[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else if (accept) begin
            pc_d = pc_q + 32'd4;
        end

        if (accept) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end

        // Flush beats Stall; anything not accepted becomes a bubble tagged with the PC.
        if (Flush) begin
            ifid_pc_d    = pc_q;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end else if (Stall) begin
            ifid_pc_d    = ifid_pc_q;
            ifid_instr_d = ifid_instr_q;
            ifid_valid_d = ifid_valid_q;
        end else if (accept) begin
            ifid_pc_d    = pc_q;
            ifid_instr_d = imem_rdata;
            ifid_valid_d = 1'b1;
        end else begin
            ifid_pc_d    = pc_q;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            ifid_pc_q     <= RESET_PC;
            ifid_instr_q  <= NOP_INSTR;
            ifid_valid_q  <= 1'b0;
            misalign_q    <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ifid_pc_q     <= ifid_pc_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_valid_q  <= ifid_valid_d;
            misalign_q    <= misalign_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr    = pc_q;
    assign IFID_pc      = ifid_pc_q;
    assign IFID_instr   = ifid_instr_q;
    assign IFID_valid   = ifid_valid_q;
    assign misalign_err = misalign_q;
    assign fetch_count  = fetch_count_q;

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 Parameters (name, default, meaning): RESET_PC, 32'h0000_0000, PC after reset; TRAP_VEC, 32'h0000_0100, target for PCSrc=11; NOP_INSTR, 32'h0000_0013, bubble encoding.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 Stall  in  1  hold PC and IF/ID outputs.
REQ-005 Flush  in  1  replace IF/ID contents with bubble.
REQ-006 PCSrc  in  2  next-PC select: 00 sequential, 01 branch_target, 10 jump_target, 11 TRAP_VEC.
REQ-007 branch_target, jump_target  in  32 each  redirect addresses.
REQ-008 imem_addr  out  32  fetch address, always equals current PC.
REQ-009 imem_req  out  1  fetch request.
REQ-010 imem_ready  in  1  memory has imem_rdata valid this cycle.
REQ-011 imem_rdata  in  32  fetched instruction.
REQ-012 IFID_pc, IFID_instr  out  32 each  IF/ID register outputs.
REQ-013 IFID_valid  out  1  IFID_instr is a real instruction.
REQ-014 misalign_err  out  1  sticky: a redirect target had bits[1:0]!=0.
REQ-015 fetch_count  out  32  count of accepted instructions.

Function
REQ-016 The FSM SHALL have two states: BOOT and RUN; reset enters BOOT; BOOT->RUN unconditionally after one cycle; RUN holds until reset.
REQ-017 imem_req SHALL be 0 in BOOT and 1 in RUN.
REQ-018 Accept SHALL be defined as RUN & imem_req & imem_ready & ~Stall & ~Flush & (PCSrc==00).
REQ-019 Redirect SHALL be defined as RUN & (PCSrc!=00), independent of Stall and imem_ready.
REQ-020 Next PC SHALL be, in priority order: redirect -> selected target with bits[1:0] forced to 00; accept -> PC+4 (modulo 2^32, wraps FFFF_FFFC->0000_0000); otherwise -> PC held.
REQ-021 On redirect with target[1:0]!=00, misalign_err SHALL set the next cycle and remain 1 until reset.
REQ-022 IF/ID update priority: Flush -> IFID_instr=NOP_INSTR, IFID_valid=0, IFID_pc=PC; else Stall -> all IF/ID outputs held; else accept -> IFID_pc=PC, IFID_instr=imem_rdata, IFID_valid=1; else -> bubble as for Flush.
REQ-023 Flush SHALL take priority over Stall when both are 1 in the same cycle.
REQ-024 A fetch not accepted because of Stall SHALL be reissued at the same address; imem_rdata of that cycle SHALL be discarded (memory reads are side-effect free).
REQ-025 An imem_ready=1 in a redirect cycle SHALL be discarded; the next request goes to the new target.
REQ-026 fetch_count SHALL increment by 1 on every accept and wrap from FFFF_FFFF to 0.
REQ-027 Latency: an instruction accepted in cycle N SHALL appear on IFID_* in cycle N+1.
REQ-028 All outputs SHALL be registered except imem_addr (PC register) and imem_req (state decode).

Reset
REQ-029 While rst=0, asynchronously: state=BOOT, PC=RESET_PC, IFID_pc=RESET_PC, IFID_instr=NOP_INSTR, IFID_valid=0, misalign_err=0, fetch_count=0, imem_req=0.
REQ-030 Reset asserted mid-stall or mid-redirect SHALL discard all pending state; first request after release SHALL be at RESET_PC, one cycle after BOOT.

Verification
REQ-031 Release reset, imem_ready=1 constantly, rdata=addr^A5A5_0000 -> imem_req=1 from 2nd cycle; IFID_pc sequence 0,4,8,... with IFID_valid=1; fetch_count=3 after 3 accepts.
REQ-032 Stall=1 for 3 cycles at PC=0x10 -> PC stays 0x10, IFID outputs frozen, fetch_count unchanged; after release next IFID_pc=0x10.
REQ-033 PCSrc=01, branch_target=0x200, Flush=1, Stall=1, imem_ready=1 same cycle -> next cycle PC=0x200, IFID_valid=0, IFID_instr=0x0000_0013; following IFID_pc=0x200.
REQ-034 PCSrc=10, jump_target=0x0000_0102 -> PC=0x100, misalign_err=1 and sticky across later fetches.
REQ-035 imem_ready=0 for 2 cycles at PC=0x40 -> imem_addr holds 0x40, two bubbles (IFID_valid=0), then IFID_pc=0x40 with valid=1.
REQ-036 PC at 0xFFFF_FFFC accepted -> next PC=0x0000_0000; rst pulsed low mid-stall -> all outputs at reset values immediately, no clock edge required.
